nubus_slave_ctrl: RTL and testbench
===================================

# nubus_slave_ctrl

NuBus slave-side transaction responder: the card's response end of the bus, opposite the master-side driver that issues START*/RQST*. It samples START*, decodes slot-space address and transfer mode, runs one local memory access through a valid/ready handshake, and returns ACK* with TM1*/TM0* status. For reads it also drives the read data on AD*. It ignores attention cycles. It asserts `slv_ackcyn_o` so the card-level bus drivers can enable their ACK/TM outputs.

## Interface
- `WAIT_LIMIT`, default 200: maximum WAIT-state clocks before the block gives up with try-again-later status. Legal range 1..254; must stay below the 255-clock bus timeout.
- `SUPER_EN`, default 0: 1 also accepts super-slot space (ad[31:28] == id).
- `nub_clkn`  in  1  NuBus clock. All state updates on its rising edge.
- `nub_reset`  in  1  asynchronous, active-high reset.
- `nub_idn`  in  4  slot ID, active-low.
- `nub_startn`  in  1  START*.
- `nub_ackn`  in  1  ACK*, as seen on the bus.
- `nub_tm0n`, `nub_tm1n`  in  1 each  TM0*, TM1*.
- `nub_adn`  in  32  AD* bus, active-low.
- `nub_ackn_o`  out  1  ACK* value.
- `nub_tm0n_o`, `nub_tm1n_o`  out  1 each  status value.
- `slv_ackcyn_o`  out  1  low = ACK cycle. Enables ACK*/TM* drivers.
- `nub_adn_o`  out  32  read data, inverted.
- `slv_adoen_o`  out  1  low = drive AD*.
- `mem_valid_o`  out  1  local request.
- `mem_write_o`  out  1  1 = write.
- `mem_addr_o`  out  32  {ad[31:2], 2'b00}.
- `mem_wstrb_o`  out  4  byte lanes.
- `mem_wdata_o`  out  32  write data, active-high.
- `mem_ready_i`  in  1  access done.
- `mem_rdata_i`  in  32  read data.

## Operation
- Internal signals are active-high inversions of the bus pins: ad = ~nub_adn, tm1 = ~nub_tm1n, tm0 = ~nub_tm0n, start = ~nub_startn, ack = ~nub_ackn.
- Address match: ad[31:24] == {4'hF, ~nub_idn}. If SUPER_EN, ad[31:28] == ~nub_idn also matches.
- Transfer decode at START:
  - tm1 = 1 is write; tm1 = 0 is read.
  - tm0 = 1 is a byte access; the strobe is one-hot at lane ad[1:0].
  - tm0 = 0 decodes by ad[1:0]: 00 word (4'b1111), 01 low half (4'b0011), 11 high half (4'b1100), 10 block (illegal).
- Response status on {tm1, tm0} during ACK: complete 11, error 10, try-again-later 00.
- FSM states: IDLE, DATA, WAIT, ACK.
  - IDLE: on start & ~ack & match, latch address/strobe/direction and go to DATA. start & ack is an attention cycle (NULL/LOCK): no response, stay IDLE. A non-matching START also stays IDLE.
  - DATA: latch wdata = ad (the master's data cycle). If the transfer is illegal, set status error and go to ACK with no memory access. Otherwise assert mem_valid_o and go to WAIT.
  - WAIT: hold mem_valid_o and all mem_* outputs stable. When mem_ready_i is high, latch mem_rdata_i, set status complete, drop mem_valid_o, and go to ACK. When the wait counter reaches WAIT_LIMIT, set status try-again-later, drop mem_valid_o, and go to ACK.
  - ACK: drive nub_ackn_o = 0 with the status TM and slv_ackcyn_o = 0 for exactly one clock. For a completed read, also drive slv_adoen_o = 0 with nub_adn_o = ~rdata. Then return to IDLE.
- START sampled in DATA/WAIT/ACK is ignored.
- mem_ready_i outside WAIT is ignored. Local logic must tolerate mem_valid_o being withdrawn on timeout.
- Error and try-again responses never drive AD*.
- Wait counter: 8 bits, cleared on entry to WAIT, increments each WAIT clock without ready.
- If ready and the limit coincide in the same clock, ready wins (status complete).

## Timing
- Reset: the asynchronous assert forces IDLE immediately, even mid-transaction. While in reset:
  - mem_valid_o = 0, mem_write_o = 0, mem_addr_o / mem_wstrb_o / mem_wdata_o = 0.
  - nub_ackn_o, nub_tm0n_o, nub_tm1n_o, slv_ackcyn_o, slv_adoen_o all = 1.
  - nub_adn_o = 32'hFFFFFFFF.
- Latency, with START sampled at edge N:
  - DATA is entered at N; mem_valid_o goes high after N+1.
  - If mem_ready_i is high at N+2, ACK is driven during N+2..N+3.
  - Minimum START-to-ACK is therefore 3 clocks.
- Illegal transfer: ACK is driven during N+1..N+2.
- Timeout: with ready never asserted, ACK begins WAIT_LIMIT clocks after WAIT entry.
- Back-to-back: a new START may be sampled on the clock right after ACK.

## Test plan
- Word write, id=4'h9, ad=32'hF9000010, tm1=1 tm0=0, data 32'hDEADBEEF, ready after 2 WAIT clocks -> mem_addr_o=F9000010, mem_wstrb_o=1111, mem_wdata_o=DEADBEEF, one-clock ACK with nub_tm1n_o=0 nub_tm0n_o=0, AD* never driven.
- Byte read, ad[1:0]=2, rdata 32'h12345678, ready immediately -> mem_wstrb_o=0100, ACK at START+3 clocks, nub_adn_o=32'hEDCBA987, slv_adoen_o low for that clock only.
- Block code (tm0=0, ad[1:0]=10) -> mem_valid_o stays 0; ACK one clock after DATA with status 10 (nub_tm1n_o=0, nub_tm0n_o=1).
- Ready held low, WAIT_LIMIT=4 -> mem_valid_o high for exactly 4 clocks; ACK with status 00; a late ready is ignored.
- Attention cycle (START and ACK both asserted) and START to slot F8 when id=9 -> no mem_valid_o, no ACK.
- nub_reset pulsed during WAIT -> mem_valid_o falls asynchronously; all outputs at reset values; the next matching START completes normally.

Source files
------------

// File: rtl/nubus_slave_ctrl_if.sv
// NuBus slave-side pin bundle plus local memory request/response channel.
// The slave modport is the responder's view; the master modport is the bus/memory side.
interface nubus_slave_ctrl_if;
  logic [3:0]  nub_idn;
  logic        nub_startn;
  logic        nub_ackn;
  logic        nub_tm0n;
  logic        nub_tm1n;
  logic [31:0] nub_adn;
  logic        nub_ackn_o;
  logic        nub_tm0n_o;
  logic        nub_tm1n_o;
  logic        slv_ackcyn_o;
  logic [31:0] nub_adn_o;
  logic        slv_adoen_o;
  logic        mem_valid_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  nub_idn, nub_startn, nub_ackn, nub_tm0n, nub_tm1n, nub_adn,
    output nub_ackn_o, nub_tm0n_o, nub_tm1n_o, slv_ackcyn_o, nub_adn_o, slv_adoen_o,
    output mem_valid_o, mem_write_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport master (
    output nub_idn, nub_startn, nub_ackn, nub_tm0n, nub_tm1n, nub_adn,
    input  nub_ackn_o, nub_tm0n_o, nub_tm1n_o, slv_ackcyn_o, nub_adn_o, slv_adoen_o,
    input  mem_valid_o, mem_write_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave responder: START decode -> one local valid/ready access -> one-clock ACK with TM status.
// START-to-ACK is 3 clocks minimum; a stalled memory is abandoned after WAIT_LIMIT clocks with try-again-later.
module nubus_slave_ctrl #(
  parameter int WAIT_LIMIT = 200,
  parameter bit SUPER_EN   = 1'b0
) (
  input  logic               nub_clkn,
  input  logic               nub_reset,
  nubus_slave_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  // status codes as {tm1, tm0}, active-high
  localparam logic [1:0] ST_OK    = 2'b11;
  localparam logic [1:0] ST_ERR   = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b00;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [31:0] ad;
  logic        start;
  logic        ack_in;
  logic        tm1;
  logic        tm0;
  logic [3:0]  id;
  logic        match;
  logic [3:0]  strb_dec;
  logic        illegal_dec;
  logic [7:0]  cnt_inc;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;
  logic        illegal_q, illegal_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  status_q, status_d;
  logic        rd_ok_q, rd_ok_d;
  logic        mem_valid_q, mem_valid_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        in_ack;

  assign ad      = ~bus.nub_adn;
  assign start   = ~bus.nub_startn;
  assign ack_in  = ~bus.nub_ackn;
  assign tm1     = ~bus.nub_tm1n;
  assign tm0     = ~bus.nub_tm0n;
  assign id      = ~bus.nub_idn;
  assign cnt_inc = wait_cnt_q + 8'd1;

  always_comb begin
    match = (ad[31:24] == {4'hF, id});
    if (SUPER_EN && (ad[31:28] == id)) match = 1'b1;
  end

  always_comb begin
    strb_dec    = 4'b0000;
    illegal_dec = 1'b0;
    if (tm0) begin
      strb_dec = 4'b0001 << ad[1:0];
    end else begin
      case (ad[1:0])
        2'b00:   strb_dec = 4'b1111;
        2'b01:   strb_dec = 4'b0011;
        2'b11:   strb_dec = 4'b1100;
        default: illegal_dec = 1'b1;  // block transfers are not supported
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    illegal_d   = illegal_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    rd_ok_d     = rd_ok_q;
    mem_valid_d = mem_valid_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        // start with ack asserted is an attention cycle and gets no response
        if (start && !ack_in && match) begin
          addr_d    = {ad[31:2], 2'b00};
          wstrb_d   = strb_dec;
          write_d   = tm1;
          illegal_d = illegal_dec;
          rd_ok_d   = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        wdata_d = ad;
        if (illegal_q) begin
          status_d = ST_ERR;
          state_d  = S_ACK;
        end else begin
          mem_valid_d = 1'b1;
          wait_cnt_d  = 8'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_ready_i) begin
          rdata_d     = bus.mem_rdata_i;
          status_d    = ST_OK;
          rd_ok_d     = ~write_q;
          mem_valid_d = 1'b0;
          state_d     = S_ACK;
        end else if (cnt_inc == LIMIT) begin
          status_d    = ST_RETRY;
          mem_valid_d = 1'b0;
          state_d     = S_ACK;
        end else begin
          wait_cnt_d = cnt_inc;
        end
      end
      S_ACK: begin
        rd_ok_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      illegal_q   <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= ST_RETRY;
      rd_ok_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      illegal_q   <= illegal_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      rd_ok_q     <= rd_ok_d;
      mem_valid_q <= mem_valid_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign in_ack = (state_q == S_ACK);

  assign bus.nub_ackn_o   = ~in_ack;
  assign bus.slv_ackcyn_o = ~in_ack;
  assign bus.nub_tm1n_o   = ~(in_ack & status_q[1]);
  assign bus.nub_tm0n_o   = ~(in_ack & status_q[0]);
  assign bus.slv_adoen_o  = ~(in_ack & rd_ok_q);
  assign bus.nub_adn_o    = (in_ack & rd_ok_q) ? ~rdata_q : 32'hFFFF_FFFF;

  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_write_o = write_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wstrb_o = wstrb_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Directed bench for nubus_slave_ctrl: word write, byte read, block error, timeout,
// ignored attention/foreign-slot STARTs and asynchronous reset mid-transaction.
module tb_nubus_slave_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   vcnt;
  int   acnt;
  logic [1:0] ack_tm;
  logic       ack_oe;

  nubus_slave_ctrl_if bus_if ();

  nubus_slave_ctrl #(.WAIT_LIMIT(4), .SUPER_EN(1'b0)) dut (
    .nub_clkn  (clk),
    .nub_reset (rst),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.nub_startn = 1'b1;
    bus_if.nub_ackn   = 1'b1;
    bus_if.nub_tm1n   = 1'b1;
    bus_if.nub_tm0n   = 1'b1;
    bus_if.nub_adn    = 32'hFFFF_FFFF;
  endtask

  // drive START for one clock, then put data on AD* for the master's data cycle
  task automatic issue(input logic [31:0] a, input logic t1, input logic t0,
                       input logic attn, input logic [31:0] d);
    @(negedge clk);
    bus_if.nub_startn = 1'b0;
    bus_if.nub_ackn   = ~attn;
    bus_if.nub_tm1n   = ~t1;
    bus_if.nub_tm0n   = ~t0;
    bus_if.nub_adn    = ~a;
    @(negedge clk);
    bus_idle();
    bus_if.nub_adn = ~d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ackn"},  32'(bus_if.nub_ackn_o),   32'd1);
    chk({tag, "_ackcy"}, 32'(bus_if.slv_ackcyn_o), 32'd1);
    chk({tag, "_tm1n"},  32'(bus_if.nub_tm1n_o),   32'd1);
    chk({tag, "_tm0n"},  32'(bus_if.nub_tm0n_o),   32'd1);
    chk({tag, "_adoen"}, 32'(bus_if.slv_adoen_o),  32'd1);
    chk({tag, "_adn"},   bus_if.nub_adn_o,         32'hFFFF_FFFF);
  endtask

  initial begin
    bus_idle();
    bus_if.nub_idn     = ~4'h9;
    bus_if.mem_ready_i = 1'b0;
    bus_if.mem_rdata_i = 32'h0;
    #1;
    chk("rst_valid", 32'(bus_if.mem_valid_o), 32'd0);
    chk("rst_addr",  bus_if.mem_addr_o, 32'd0);
    chk_quiet("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // word write, ready after two WAIT clocks
    issue(32'hF900_0010, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("ww_valid_data", 32'(bus_if.mem_valid_o), 32'd0);
    @(negedge clk);
    chk("ww_valid",  32'(bus_if.mem_valid_o), 32'd1);
    chk("ww_write",  32'(bus_if.mem_write_o), 32'd1);
    chk("ww_addr",   bus_if.mem_addr_o, 32'hF900_0010);
    chk("ww_wstrb",  32'(bus_if.mem_wstrb_o), 32'hF);
    chk("ww_wdata",  bus_if.mem_wdata_o, 32'hDEAD_BEEF);
    chk("ww_noack",  32'(bus_if.nub_ackn_o), 32'd1);
    @(negedge clk);
    chk("ww_valid2", 32'(bus_if.mem_valid_o), 32'd1);
    @(negedge clk);
    bus_if.mem_ready_i = 1'b1;
    @(negedge clk);
    bus_if.mem_ready_i = 1'b0;
    chk("ww_ackn",   32'(bus_if.nub_ackn_o), 32'd0);
    chk("ww_ackcy",  32'(bus_if.slv_ackcyn_o), 32'd0);
    chk("ww_tm1n",   32'(bus_if.nub_tm1n_o), 32'd0);
    chk("ww_tm0n",   32'(bus_if.nub_tm0n_o), 32'd0);
    chk("ww_adoen",  32'(bus_if.slv_adoen_o), 32'd1);
    chk("ww_vdrop",  32'(bus_if.mem_valid_o), 32'd0);
    @(negedge clk);
    chk_quiet("ww_after");

    // byte read lane 2, ready already high when WAIT is entered
    issue(32'hF900_0012, 1'b0, 1'b1, 1'b0, 32'h0);
    bus_if.mem_ready_i = 1'b1;
    bus_if.mem_rdata_i = 32'h1234_5678;
    chk("br_valid_data", 32'(bus_if.mem_valid_o), 32'd0);
    chk("br_noack_data", 32'(bus_if.nub_ackn_o), 32'd1);
    @(negedge clk);
    chk("br_valid",  32'(bus_if.mem_valid_o), 32'd1);
    chk("br_write",  32'(bus_if.mem_write_o), 32'd0);
    chk("br_wstrb",  32'(bus_if.mem_wstrb_o), 32'h4);
    chk("br_addr",   bus_if.mem_addr_o, 32'hF900_0010);
    chk("br_noack",  32'(bus_if.nub_ackn_o), 32'd1);
    @(negedge clk);
    bus_if.mem_ready_i = 1'b0;
    chk("br_ackn",   32'(bus_if.nub_ackn_o), 32'd0);
    chk("br_tm1n",   32'(bus_if.nub_tm1n_o), 32'd0);
    chk("br_tm0n",   32'(bus_if.nub_tm0n_o), 32'd0);
    chk("br_adoen",  32'(bus_if.slv_adoen_o), 32'd0);
    chk("br_adn",    bus_if.nub_adn_o, 32'hEDCB_A987);
    @(negedge clk);
    chk_quiet("br_after");

    // block transfer code: error status, no memory access
    issue(32'hF900_0012, 1'b1, 1'b0, 1'b0, 32'h5555_5555);
    chk("blk_valid_data", 32'(bus_if.mem_valid_o), 32'd0);
    @(negedge clk);
    chk("blk_valid", 32'(bus_if.mem_valid_o), 32'd0);
    chk("blk_ackn",  32'(bus_if.nub_ackn_o), 32'd0);
    chk("blk_tm1n",  32'(bus_if.nub_tm1n_o), 32'd0);
    chk("blk_tm0n",  32'(bus_if.nub_tm0n_o), 32'd1);
    chk("blk_adoen", 32'(bus_if.slv_adoen_o), 32'd1);
    @(negedge clk);
    chk_quiet("blk_after");

    // timeout: ready never comes, WAIT_LIMIT = 4
    issue(32'hF900_0020, 1'b0, 1'b0, 1'b0, 32'h0);
    vcnt = 0; acnt = 0; ack_tm = 2'b11; ack_oe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.mem_valid_o) vcnt++;
      if (!bus_if.nub_ackn_o) begin
        acnt++;
        ack_tm = {bus_if.nub_tm1n_o, bus_if.nub_tm0n_o};
        ack_oe = bus_if.slv_adoen_o;
      end
    end
    chk("to_valid_clocks", 32'(vcnt), 32'd4);
    chk("to_ack_clocks",   32'(acnt), 32'd1);
    chk("to_status_n",     32'(ack_tm), 32'b11);
    chk("to_adoen",        32'(ack_oe), 32'd1);
    bus_if.mem_ready_i = 1'b1;
    vcnt = 0; acnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_if.mem_valid_o) vcnt++;
      if (!bus_if.nub_ackn_o) acnt++;
    end
    bus_if.mem_ready_i = 1'b0;
    chk("late_rdy_valid", 32'(vcnt), 32'd0);
    chk("late_rdy_ack",   32'(acnt), 32'd0);

    // attention cycle and a START for another slot: both ignored
    issue(32'hF900_0000, 1'b0, 1'b0, 1'b1, 32'h0);
    vcnt = 0; acnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.mem_valid_o) vcnt++;
      if (!bus_if.nub_ackn_o) acnt++;
    end
    chk("attn_valid", 32'(vcnt), 32'd0);
    chk("attn_ack",   32'(acnt), 32'd0);
    issue(32'hF800_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    vcnt = 0; acnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.mem_valid_o) vcnt++;
      if (!bus_if.nub_ackn_o) acnt++;
    end
    chk("slot_valid", 32'(vcnt), 32'd0);
    chk("slot_ack",   32'(acnt), 32'd0);

    // asynchronous reset while waiting on memory
    issue(32'hF900_0030, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    chk("ar_valid_pre", 32'(bus_if.mem_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",  32'(bus_if.mem_valid_o), 32'd0);
    chk("ar_write",  32'(bus_if.mem_write_o), 32'd0);
    chk("ar_addr",   bus_if.mem_addr_o, 32'd0);
    chk("ar_wstrb",  32'(bus_if.mem_wstrb_o), 32'd0);
    chk("ar_wdata",  bus_if.mem_wdata_o, 32'd0);
    chk_quiet("ar");
    @(negedge clk);
    rst = 1'b0;

    // matching word read right after reset completes normally
    issue(32'hF900_0004, 1'b0, 1'b0, 1'b0, 32'h0);
    bus_if.mem_ready_i = 1'b1;
    bus_if.mem_rdata_i = 32'hA5A5_0F0F;
    @(negedge clk);
    chk("pr_valid", 32'(bus_if.mem_valid_o), 32'd1);
    chk("pr_addr",  bus_if.mem_addr_o, 32'hF900_0004);
    chk("pr_wstrb", 32'(bus_if.mem_wstrb_o), 32'hF);
    @(negedge clk);
    bus_if.mem_ready_i = 1'b0;
    chk("pr_ackn",  32'(bus_if.nub_ackn_o), 32'd0);
    chk("pr_tm",    32'({bus_if.nub_tm1n_o, bus_if.nub_tm0n_o}), 32'b00);
    chk("pr_adoen", 32'(bus_if.slv_adoen_o), 32'd0);
    chk("pr_adn",   bus_if.nub_adn_o, 32'h5A5A_F0F0);
    @(negedge clk);
    chk_quiet("pr_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
